pwm_to_fxp: RTL
===============

Name: pwm_to_fxp

Overview:
- Capture-side counterpart of the fixed-point-to-PWM slice in the ikinematics servo path.
- Measures the high time of an incoming servo PWM pulse in prescaled ticks.
- Places the tick count back into the same fixed-point bit field the forward path extracts from.
- Used for servo readback and loopback checking of the ikinematics angle outputs.

Parameters:
- FXP_WIDTH, 20: width of the fixed-point result.
- PWM_OFFSET, 8: MSB position of the PWM field inside the fixed-point word.
- PWM_WIDTH, 8: width of the tick counter and of the PWM field.
- PRESCALE, 4: clocks per measurement tick. Must be >= 1.
- TIMEOUT_CYCLES, 2000000: clocks without a completed pulse before LOST asserts.
- Legal range: PWM_WIDTH-1 <= PWM_OFFSET <= FXP_WIDTH-1.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  asynchronous active-low reset.
- EN  in  1  capture enable, synchronous.
- PWM_IN  in  1  asynchronous servo pulse input.
- FXP_OUT  out  FXP_WIDTH  last measured value.
- FXP_VALID  out  1  one-cycle strobe when FXP_OUT updates.
- ERR_OVF  out  1  last measurement saturated.
- LOST  out  1  no complete pulse within TIMEOUT_CYCLES.

Behaviour:
- Reset (async assert, sync release): FXP_OUT=0, FXP_VALID=0, ERR_OVF=0, LOST=0, state IDLE, synchronizer flops=0, all counters 0.
- Input conditioning: two-flop synchronizer on PWM_IN gives s. A registered copy p gives rise=s&~p and fall=~s&p.
- H = number of consecutive clocks with s=1 in one pulse.
- Measured count C = min(floor(H/PRESCALE), 2^PWM_WIDTH-1).
- FSM states:
  - IDLE: wait for s=0, then go to ARMED. This guarantees no partial first pulse.
  - ARMED: on rise, clear the prescaler and count (the rise cycle counts as the first high cycle), then go to HIGH.
  - HIGH: the prescaler counts clocks. On wrap (PRESCALE-1 -> 0) the count increments, saturating at all-ones and setting an internal overflow flag. On fall, register the result and go to ARMED.
- Output mapping on fall:
  - FXP_OUT[PWM_OFFSET -: PWM_WIDTH] = C; all other bits 0.
  - ERR_OVF = overflow flag, updated on every result.
  - FXP_VALID = 1 for exactly one cycle.
- Latency: FXP_VALID is high 3 ACLK edges after the first edge that samples PWM_IN low (2 sync + 1 output register).
- FXP_OUT holds its value between strobes.
- EN=0: synchronously forces IDLE and aborts any measurement in progress; no FXP_VALID is issued. FXP_OUT, ERR_OVF and LOST hold. Prescaler, count and timeout counter clear. EN re-asserted while s=1 still waits for a low level first.
- Timeout counter:
  - Counts clocks while EN=1 and clears on every FXP_VALID.
  - On reaching TIMEOUT_CYCLES, LOST=1 and the counter holds there.
  - LOST clears on the next FXP_VALID.
  - A pulse stuck high reports LOST and produces no result until the fall.
- Simultaneous events:
  - rise and fall cannot coincide by construction.
  - Timeout threshold reached in the same cycle as FXP_VALID: the FXP_VALID clear wins, so LOST=0.
- Reset mid-pulse: measurement is discarded; after release the block requires a low level before arming.
- Counter widths:
  - prescaler: $clog2(PRESCALE) bits, minimum 1.
  - timeout counter: $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package/include ikin_pwm_pkg holds:
  - FSM state encodings IDLE=2'd0, ARMED=2'd1, HIGH=2'd2.
  - Default PWM_OFFSET/PWM_WIDTH constants, shared with the forward fixed-point-to-PWM path so both ends agree on the field.
- One sub-module, pwm_in_sync: 2-flop synchronizer plus edge detector, outputs s, rise, fall, async active-low reset to 0.

Test Plan:
- Defaults, PRESCALE=4, PWM_IN low 10 clocks then high 40 clocks -> one FXP_VALID, FXP_OUT=0x00014 (C=10, shifted left 1), ERR_OVF=0.
- High 1100 clocks -> C saturates at 255, FXP_OUT=0x001FE, ERR_OVF=1. A following 40-clock pulse -> FXP_OUT=0x00014, ERR_OVF=0.
- PWM_IN already high when EN rises, stays high 30 clocks, then a full 20-clock pulse -> only one FXP_VALID, FXP_OUT=0x0000A.
- ARESETN pulsed low 20 clocks into a 40-clock pulse -> outputs 0 immediately; no FXP_VALID for that pulse; next full 40-clock pulse -> 0x00014.
- TIMEOUT_CYCLES=100, PWM_IN held low 150 clocks -> LOST=1 at cycle 100. A 16-clock pulse -> FXP_VALID, FXP_OUT=0x00008, LOST=0 in the same cycle.
- EN dropped at clock 20 of a 40-clock pulse, re-raised while PWM_IN is low -> no FXP_VALID for the aborted pulse, FXP_OUT holds its previous value.

Source files
------------

// File: rtl/ikin_pwm_pkg.sv
// Definitions shared by the servo PWM forward path and its capture-side readback.
// Both ends use the same PWM field location inside the fixed-point word.
package ikin_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2
    } pwm_state_e;

    localparam int unsigned DEF_PWM_OFFSET = 8;
    localparam int unsigned DEF_PWM_WIDTH  = 8;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the asynchronous PWM input, plus a delayed copy
// of the synchronized level used for rise/fall detection.
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            p_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pwm};
            p_q    <= sync_q[1];
        end
    end

    assign s    = sync_q[1];
    assign rise = sync_q[1] & ~p_q;
    assign fall = ~sync_q[1] & p_q;

endmodule

// File: rtl/pwm_to_fxp.sv
// Measures servo PWM high time in prescaled ticks and places the count into
// the fixed-point PWM field, with saturation and lost-signal reporting.
module pwm_to_fxp
    import ikin_pwm_pkg::*;
#(
    parameter int unsigned FXP_WIDTH      = 20,
    parameter int unsigned PWM_OFFSET     = DEF_PWM_OFFSET,
    parameter int unsigned PWM_WIDTH      = DEF_PWM_WIDTH,
    parameter int unsigned PRESCALE       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 EN,
    input  logic                 PWM_IN,
    output logic [FXP_WIDTH-1:0] FXP_OUT,
    output logic                 FXP_VALID,
    output logic                 ERR_OVF,
    output logic                 LOST
);

    localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic s, rise, fall;

    pwm_in_sync u_sync (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .pwm   (PWM_IN),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    pwm_state_e           state_q, state_d;
    logic [PSC_W-1:0]     psc_q, psc_d, psc_base, psc_step;
    logic [PWM_WIDTH-1:0] cnt_q, cnt_d, cnt_base, cnt_step;
    logic                 ovf_q, ovf_d, ovf_base, ovf_step;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [1:0]           settle_q, settle_d;
    logic [FXP_WIDTH-1:0] fxp_q, fxp_d;
    logic                 valid_q, valid_d, err_q, err_d, lost_q, lost_d;
    logic                 counting, result;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // settle_q keeps IDLE from arming on the reset value of the synchronizer
    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!s && settle_q == 2'd3) state_d = ARMED;
                ARMED:   if (rise) state_d = HIGH;
                HIGH:    if (fall) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    // One high-cycle step of the prescaler/count; the rise cycle steps from zero
    always_comb begin
        psc_base = psc_q;
        cnt_base = cnt_q;
        ovf_base = ovf_q;
        if (state_q == ARMED) begin
            psc_base = '0;
            cnt_base = '0;
            ovf_base = 1'b0;
        end
        psc_step = psc_base + 1'b1;
        cnt_step = cnt_base;
        ovf_step = ovf_base;
        if (psc_base == PSC_MAX) begin
            psc_step = '0;
            if (&cnt_base) ovf_step = 1'b1;
            else           cnt_step = cnt_base + 1'b1;
        end
    end

    always_comb begin
        result   = EN && (state_q == HIGH) && fall;
        counting = EN && (((state_q == ARMED) && rise) || ((state_q == HIGH) && s));

        psc_d = psc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (!EN) begin
            psc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (counting) begin
            psc_d = psc_step;
            cnt_d = cnt_step;
            ovf_d = ovf_step;
        end

        if (!EN || result)       tmo_d = '0;
        else if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
        else                     tmo_d = tmo_q;

        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

        fxp_d = fxp_q;
        if (result) begin
            fxp_d = '0;
            fxp_d[PWM_OFFSET -: PWM_WIDTH] = cnt_q;
        end
        valid_d = result;
        err_d   = result ? ovf_q : err_q;
        // a result in the same cycle as the threshold clears LOST
        if (result)                lost_d = 1'b0;
        else if (tmo_d == TMO_MAX) lost_d = 1'b1;
        else                       lost_d = lost_q;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            psc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= '0;
            settle_q <= 2'd0;
            fxp_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            psc_q    <= psc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            settle_q <= settle_d;
            fxp_q    <= fxp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            lost_q   <= lost_d;
        end
    end

    assign FXP_OUT   = fxp_q;
    assign FXP_VALID = valid_q;
    assign ERR_OVF   = err_q;
    assign LOST      = lost_q;

endmodule
